spi_sensor_responder: RTL and testbench

- Synthesizable SPI slave model of the multichannel sensor. It sits on the sensor side of the SPI link, opposite the FPGA's SPI master controller.
- Receives 16-bit command frames on MOSI and executes CONVERT, READ, WRITE, CALIBRATE and CLEAR commands against an internal register file and sample generator.
- Returns each command's result on MISO during a later frame.
- Used in simulation and in hardware loopback to exercise the master controller without a physical sensor.

---
 rtl/spi_sensor_responder.sv | 189 ++++++++++++++++++
 tb/tb_spi_sensor_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_responder.sv
// SPI slave stand-in for the multichannel sensor (CPOL=0, CPHA=0, 16-bit frames).
// Decodes CONVERT / WRITE / READ / CALIBRATE / CLEAR and returns each result
// in a later frame through a small response pipeline.
// Optional build macro RESP_PIPE2_EN: two-deep response pipeline (frame N
// answered in frame N+2, like the real part); default is one deep.
module spi_sensor_responder #(
  parameter int         FRAME_BITS   = 16,
  parameter int         NUM_CHANNELS = 32,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] CHIP_ID      = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        cs_b,
  input  logic        mosi,
  output logic        miso,
  output logic        frame_done,
  output logic [15:0] last_cmd,
  output logic [31:0] frame_count,
  output logic        err_short_frame
);

`ifdef RESP_PIPE2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);
  localparam int         NUM_REGS  = 40;

  // {sclk, cs_b, mosi} synchronizer; idle value keeps cs_b high so reset
  // release never looks like a frame start.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic        sclk_prev_q, cs_prev_q;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [15:0] shift_in_q, shift_in_d;
  logic [15:0] shift_out_q, shift_out_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_q, miso_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  logic [15:0] last_cmd_q, last_cmd_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [9:0]  sample_idx_q, sample_idx_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic [DEPTH-1:0][15:0] pipe_q, pipe_d;

  logic [5:0]  addr;
  logic [7:0]  rd_val;
  logic [15:0] resp;

  assign sclk_s    = sync_q[SYNC_STAGES-1][2];
  assign cs_s      = sync_q[SYNC_STAGES-1][1];
  assign mosi_s    = sync_q[SYNC_STAGES-1][0];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign addr      = shift_in_q[13:8];

  // Synchronizer shift: new samples enter stage 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {sclk, cs_b, mosi}};
  end

  // Register-file read view: writable bank, "INTAN" id string, chip id.
  always_comb begin
    rd_val = 8'h00;
    if (addr < 6'(NUM_REGS)) begin
      rd_val = regs_q[addr];
    end else begin
      case (addr)
        6'd40:   rd_val = 8'h49;
        6'd41:   rd_val = 8'h4E;
        6'd42:   rd_val = 8'h54;
        6'd43:   rd_val = 8'h41;
        6'd44:   rd_val = 8'h4E;
        6'd63:   rd_val = CHIP_ID;
        default: rd_val = 8'h00;
      endcase
    end
  end

  // Shift engine, frame-end decode and pipeline advance.
  always_comb begin
    shift_in_d    = shift_in_q;
    shift_out_d   = shift_out_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    frame_done_d  = 1'b0;
    err_d         = 1'b0;
    last_cmd_d    = last_cmd_q;
    frame_count_d = frame_count_q;
    sample_idx_d  = sample_idx_q;
    regs_d        = regs_q;
    pipe_d        = pipe_q;
    resp          = 16'h0000;

    if (cs_fall) begin
      shift_out_d = pipe_q[0];
      miso_d      = pipe_q[0][15];
      bit_cnt_d   = 5'd0;
    end else if (!cs_s && sclk_rise) begin
      shift_in_d = {shift_in_q[14:0], mosi_s};
      if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
    end else if (!cs_s && sclk_fall) begin
      shift_out_d = {shift_out_q[14:0], 1'b0};
      miso_d      = shift_out_q[14];
    end

    // Never tristate: drive low whenever deselected.
    if (cs_s) miso_d = 1'b0;

    if (cs_rise) begin
      if (bit_cnt_q == FRAME_LEN) begin
        case (shift_in_q[15:14])
          2'b00: begin
            if (32'(addr) < NUM_CHANNELS) begin
              resp         = {addr, sample_idx_q};
              sample_idx_d = sample_idx_q + 10'd1;
            end
          end
          2'b10: begin
            if (addr < 6'(NUM_REGS)) regs_d[addr] = shift_in_q[7:0];
            resp = {8'hFF, shift_in_q[7:0]};
          end
          2'b11: resp = {8'h00, rd_val};
          default: begin
            if (shift_in_q == 16'h5500) resp = 16'h8000;
            else if (shift_in_q == 16'h6A00) sample_idx_d = 10'd0;
          end
        endcase
        for (int i = 0; i < DEPTH - 1; i++) pipe_d[i] = pipe_q[i+1];
        pipe_d[DEPTH-1] = resp;
        last_cmd_d      = shift_in_q;
        frame_count_d   = frame_count_q + 32'd1;
        frame_done_d    = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= {SYNC_STAGES{3'b010}};
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      last_cmd_q    <= '0;
      frame_count_q <= '0;
      sample_idx_q  <= '0;
      pipe_q        <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      sync_q        <= sync_d;
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      shift_in_q    <= shift_in_d;
      shift_out_q   <= shift_out_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      last_cmd_q    <= last_cmd_d;
      frame_count_q <= frame_count_d;
      sample_idx_q  <= sample_idx_d;
      pipe_q        <= pipe_d;
      regs_q        <= regs_d;
    end
  end

  assign miso            = miso_q;
  assign frame_done      = frame_done_q;
  assign err_short_frame = err_q;
  assign last_cmd        = last_cmd_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Bench for spi_sensor_responder: bit-banged SPI master, reference model of
// the sensor, expected responses queued per frame and popped when the frame
// that carries them is clocked out.
module tb_spi_sensor_responder;
`ifdef RESP_PIPE2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_b = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        frame_done;
  logic [15:0] last_cmd;
  logic [31:0] frame_count;
  logic        err_short_frame;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  logic [7:0]  m_regs [40];
  logic [9:0]  m_idx;
  logic [15:0] m_pipe [$];
  int          m_frames;
  logic [15:0] m_last;

  spi_sensor_responder dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_b(cs_b), .mosi(mosi),
    .miso(miso), .frame_done(frame_done), .last_cmd(last_cmd),
    .frame_count(frame_count), .err_short_frame(err_short_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
    if (err_short_frame) err_cnt++;
  end

  task automatic model_reset();
    for (int i = 0; i < 40; i++) m_regs[i] = 8'h00;
    m_idx = '0;
    m_pipe.delete();
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back(16'h0000);
    m_frames = 0;
    m_last = 16'h0000;
  endtask

  task automatic model_cmd(input logic [15:0] c, output logic [15:0] r);
    logic [5:0] a;
    a = c[13:8];
    r = 16'h0000;
    if (c[15:14] == 2'b00) begin
      if (a < 6'd32) begin r = {a, m_idx}; m_idx = m_idx + 10'd1; end
    end else if (c[15:14] == 2'b10) begin
      if (a < 6'd40) m_regs[a] = c[7:0];
      r = {8'hFF, c[7:0]};
    end else if (c[15:14] == 2'b11) begin
      if (a < 6'd40) r = {8'h00, m_regs[a]};
      else if (a == 6'd40) r = 16'h0049;
      else if (a == 6'd41) r = 16'h004E;
      else if (a == 6'd42) r = 16'h0054;
      else if (a == 6'd43) r = 16'h0041;
      else if (a == 6'd44) r = 16'h004E;
      else if (a == 6'd63) r = 16'h0001;
    end else begin
      if (c == 16'h5500) r = 16'h8000;
      else if (c == 16'h6A00) m_idx = '0;
    end
  endtask

  // Raw SPI transfer of nbits; rx collects MISO sampled before each rise.
  task automatic spi_xfer(input logic [15:0] cmd, input int nbits, output logic [15:0] rx);
    rx = '0;
    cs_b = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[15-i];
      #60;
      rx = {rx[14:0], miso};
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
    end
    #60;
    cs_b = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  // Full frame: pops the response this frame should carry, pushes its own.
  task automatic send(input logic [15:0] cmd, output logic [15:0] rx, output logic [15:0] exp);
    logic [15:0] r;
    spi_xfer(cmd, 16, rx);
    exp = m_pipe.pop_front();
    model_cmd(cmd, r);
    m_pipe.push_back(r);
    m_frames++;
    m_last = cmd;
  endtask

  task automatic test_reset();
    logic [15:0] rx, exp;
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin sclk = ~sclk; #40; end
    sclk = 1'b0;
    #40;
    checks++;
    if (miso !== 1'b0 || frame_count !== 32'd0) begin
      failures++; $display("FAIL reset_hold miso=%b fc=%0d want 0/0", miso, frame_count);
    end
    reset_n = 1'b1;
    #100;
    checks++;
    if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b want=0", miso); end
    checks++;
    if (frame_count !== 32'd0) begin failures++; $display("FAIL reset_fc got=%0d want=0", frame_count); end
    checks++;
    if (last_cmd !== 16'h0000) begin failures++; $display("FAIL reset_last got=%h want=0000", last_cmd); end
    checks++;
    if (frame_done !== 1'b0 || err_short_frame !== 1'b0) begin
      failures++; $display("FAIL reset_pulses fd=%b err=%b want 0/0", frame_done, err_short_frame);
    end
    send(16'h0000, rx, exp);
    checks++;
    if (rx !== 16'h0000 || rx !== exp) begin failures++; $display("FAIL reset_first_rx got=%h want=0000", rx); end
  endtask

  task automatic run_list(input string name, input logic [15:0] cmds [], output int nfail);
    logic [15:0] rx, exp;
    int fd0;
    nfail = 0;
    fd0 = fd_cnt;
    foreach (cmds[i]) begin
      send(cmds[i], rx, exp);
      checks++;
      if (rx !== exp) begin
        failures++; nfail++;
        $display("FAIL %s_rx[%0d] cmd=%h got=%h want=%h", name, i, cmds[i], rx, exp);
      end
    end
    checks++;
    if (fd_cnt - fd0 != cmds.size()) begin
      failures++; $display("FAIL %s_frame_done got=%0d want=%0d", name, fd_cnt - fd0, cmds.size());
    end
    checks++;
    if (frame_count !== 32'(m_frames) || last_cmd !== m_last) begin
      failures++;
      $display("FAIL %s_counters fc=%0d last=%h want %0d/%h", name, frame_count, last_cmd, m_frames, m_last);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] cmds [] = '{16'h85A5, 16'hC500, 16'hC500};
    int nf;
    run_list("write_read", cmds, nf);
  endtask

  task automatic test_read_only();
    logic [15:0] cmds [] = '{16'hBF12, 16'hFF00, 16'hE800, 16'h0000};
    int nf;
    run_list("read_only", cmds, nf);
  endtask

  task automatic test_convert();
    logic [15:0] cmds [] = '{16'h6A00, 16'h0300, 16'h0300, 16'h2800, 16'h6A00, 16'h0300, 16'h5500, 16'h4400, 16'h0000};
    int nf;
    run_list("convert", cmds, nf);
  endtask

  task automatic test_short_frame();
    logic [15:0] rx, exp;
    int fd0, er0;
    logic [31:0] fc0;
    logic [15:0] lc0;
    send(16'h8177, rx, exp);
    fd0 = fd_cnt; er0 = err_cnt; fc0 = frame_count; lc0 = last_cmd;
    spi_xfer(16'hC100, 10, rx);
    checks++;
    if (err_cnt - er0 != 1) begin failures++; $display("FAIL short_err_pulses got=%0d want=1", err_cnt - er0); end
    checks++;
    if (frame_count !== fc0 || fd_cnt != fd0) begin
      failures++; $display("FAIL short_fc got=%0d want=%0d", frame_count, fc0);
    end
    checks++;
    if (last_cmd !== lc0) begin failures++; $display("FAIL short_last got=%h want=%h", last_cmd, lc0); end
    send(16'hC100, rx, exp);
    checks++;
    if (rx !== exp) begin failures++; $display("FAIL short_pending got=%h want=%h", rx, exp); end
    checks++;
    if (err_cnt - er0 != 1) begin failures++; $display("FAIL short_no_extra_err got=%0d want=1", err_cnt - er0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cmds [] = new[16];
    int nf;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: cmds[i] = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
        1: cmds[i] = {2'b10, 6'($urandom_range(0, 63)), 8'($urandom)};
        2: cmds[i] = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
        3: cmds[i] = ($urandom_range(0, 1) == 0) ? 16'h5500 : 16'h6A00;
        default: cmds[i] = {2'b01, 14'($urandom)};
      endcase
    end
    // Guarantee a write followed directly by a read of the same register.
    cmds[4] = 16'h9C3C;
    cmds[5] = 16'hDC00;
    run_list("b2b", cmds, nf);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rx, exp;
    send(16'h8123, rx, exp);
    cs_b = 1'b0;
    #100;
    for (int i = 0; i < 7; i++) begin
      mosi = i[0]; #60; sclk = 1'b1; #60; sclk = 1'b0;
    end
    reset_n = 1'b0;
    #50;
    cs_b = 1'b1;
    mosi = 1'b0;
    #50;
    reset_n = 1'b1;
    model_reset();
    #100;
    send(16'hC100, rx, exp);
    checks++;
    if (rx !== 16'h0000 || rx !== exp) begin failures++; $display("FAIL midreset_rx got=%h want=0000", rx); end
    send(16'h0000, rx, exp);
    checks++;
    if (rx !== exp) begin failures++; $display("FAIL midreset_reg1 got=%h want=%h", rx, exp); end
    checks++;
    if (frame_count !== 32'd2) begin failures++; $display("FAIL midreset_fc got=%0d want=2", frame_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_only();
    test_convert();
    test_short_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
